// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_result_drain
//  Description : Captures an NxN result matrix from the systolic array in one
//                cycle, then streams it out row-major over a valid/ready
//                handshake. A result pulse that arrives while a stream is in
//                progress is dropped and flagged in a sticky overrun bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_result_drain #(
    parameter int N = 4
) (
    input  logic                        i_clk,
    input  logic                        i_arst,
    input  logic [N-1:0][N-1:0][31:0]   i_c,
    input  logic                        i_validResult,
    output logic                        o_ready,
    output logic [31:0]                 o_data,
    output logic [$clog2(N)-1:0]        o_row,
    output logic [$clog2(N)-1:0]        o_col,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic                        o_last,
    output logic                        o_overrun,
    input  logic                        i_clearOverrun,
    output logic [15:0]                 o_matrixCount
);

    localparam int            IW         = $clog2(N);
    localparam logic [IW-1:0] c_LAST_IDX = IW'(N - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [N-1:0][N-1:0][31:0]  r_buf;
    logic [IW-1:0]              r_row;
    logic [IW-1:0]              r_col;
    logic                       r_overrun;
    logic [15:0]                r_matrix_count;
    logic                       w_fire;
    logic                       w_last;
    logic                       w_capture;

    // State register
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus handshake/status outputs
    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        w_last       = 1'b0;
        w_fire       = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready   = 1'b1;
                w_capture = i_validResult;
                if (i_validResult) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                o_valid = 1'b1;
                w_last  = (r_row == c_LAST_IDX) && (r_col == c_LAST_IDX);
                w_fire  = i_ready;
                if (w_fire && w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Snapshot of the whole matrix; only written while idle, so the stream
    // never sees later changes on i_c. Output is gated, so no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_capture) begin
            r_buf <= i_c;
        end
    end

    // Row-major read pointer, advancing only on an accepted beat
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_capture) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_fire) begin
            if (r_col == c_LAST_IDX) begin
                r_col <= '0;
                r_row <= (r_row == c_LAST_IDX) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Sticky overrun: a dropped pulse wins over a simultaneous clear
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_overrun <= 1'b0;
        end else if ((r_state == ST_STREAM) && i_validResult) begin
            r_overrun <= 1'b1;
        end else if (i_clearOverrun) begin
            r_overrun <= 1'b0;
        end
    end

    // Count of completely drained matrices, free-running wrap
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_matrix_count <= '0;
        end else if (w_fire && w_last) begin
            r_matrix_count <= r_matrix_count + 16'd1;
        end
    end

    assign o_data        = o_valid ? r_buf[r_row][r_col] : 32'd0;
    assign o_row         = r_row;
    assign o_col         = r_col;
    assign o_last        = w_last;
    assign o_overrun     = r_overrun;
    assign o_matrixCount = r_matrix_count;

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_result_drain
//  Description : Directed self-checking bench for systolic_result_drain (N=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_result_drain;

    localparam int N  = 4;
    localparam int IW = 2;

    logic                       clk;
    logic                       arst;
    logic [N-1:0][N-1:0][31:0]  c_in;
    logic                       valid_result;
    logic                       ready_out;
    logic [31:0]                data;
    logic [IW-1:0]              row;
    logic [IW-1:0]              col;
    logic                       valid;
    logic                       ready_in;
    logic                       last;
    logic                       overrun;
    logic                       clear_overrun;
    logic [15:0]                matrix_count;

    int n_tests = 0;
    int n_fail  = 0;

    systolic_result_drain #(.N(N)) dut (
        .i_clk          (clk),
        .i_arst         (arst),
        .i_c            (c_in),
        .i_validResult  (valid_result),
        .o_ready        (ready_out),
        .o_data         (data),
        .o_row          (row),
        .o_col          (col),
        .o_valid        (valid),
        .i_ready        (ready_in),
        .o_last         (last),
        .o_overrun      (overrun),
        .i_clearOverrun (clear_overrun),
        .o_matrixCount  (matrix_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected element of beat k for a matrix filled as base + 16*row + col
    function automatic logic [31:0] exp_val(input logic [31:0] base, input int k);
        return base + 32'(16 * (k / N) + (k % N));
    endfunction

    task automatic load_matrix(input logic [31:0] base);
        for (int r = 0; r < N; r++)
            for (int cc = 0; cc < N; cc++)
                c_in[r][cc] = base + 32'(16 * r + cc);
    endtask

    task automatic do_reset();
        arst = 1'b1; valid_result = 1'b0; clear_overrun = 1'b0; ready_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
    endtask

    // One-cycle result pulse; returns on the negedge where beat 0 is shown
    task automatic pulse();
        valid_result = 1'b1;
        @(negedge clk);
        valid_result = 1'b0;
    endtask

    task automatic test_reset();
        arst = 1'b1; valid_result = 1'b0; clear_overrun = 1'b0; ready_in = 1'b0;
        load_matrix(32'h0);
        @(negedge clk);
        n_tests++;
        if ({valid, last, ready_out, overrun} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_flags got v/l/r/o=%b%b%b%b exp 0010", valid, last, ready_out, overrun);
        end
        n_tests++;
        if (matrix_count !== 16'd0 || row !== '0 || col !== '0 || data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values got cnt=%h row=%0d col=%0d data=%h exp all zero",
                     matrix_count, row, col, data);
        end
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        do_reset();
        load_matrix(32'h0);
        ready_in = 1'b1;
        pulse();
        load_matrix(32'hDEAD0000);  // later input changes must not leak into the stream
        for (int k = 0; k < N * N; k++) begin
            n_tests++;
            if (valid !== 1'b1 || ready_out !== 1'b0 || data !== exp_val(32'h0, k) ||
                row !== IW'(k / N) || col !== IW'(k % N) || last !== (k == N * N - 1)) begin
                n_fail++;
                $display("FAIL basic_beat k=%0d got v=%b rdy=%b data=%h r=%0d c=%0d last=%b exp data=%h r=%0d c=%0d last=%b",
                         k, valid, ready_out, data, row, col, last, exp_val(32'h0, k), k / N, k % N, k == N * N - 1);
            end
            @(negedge clk);
        end
        n_tests++;
        if (valid !== 1'b0 || ready_out !== 1'b1 || matrix_count !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_end got v=%b rdy=%b cnt=%0d exp v=0 rdy=1 cnt=1", valid, ready_out, matrix_count);
        end
    endtask

    task automatic test_backpressure();
        int            beat;
        int            cyc;
        logic          pv;
        logic          pr;
        logic          pl;
        logic [31:0]   pd;
        logic [IW-1:0] prow;
        logic [IW-1:0] pcol;
        do_reset();
        load_matrix(32'h0);
        ready_in = 1'b0;
        pulse();
        beat = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; prow = '0; pcol = '0;
        while (beat < N * N && cyc < 200) begin
            ready_in = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (pv && !pr) begin
                n_tests++;
                if (valid !== 1'b1 || data !== pd || row !== prow || col !== pcol || last !== pl) begin
                    n_fail++;
                    $display("FAIL bp_stall cyc=%0d got v=%b data=%h r=%0d c=%0d l=%b exp data=%h r=%0d c=%0d l=%b",
                             cyc, valid, data, row, col, last, pd, prow, pcol, pl);
                end
            end
            if (valid && ready_in) begin
                n_tests++;
                if (data !== exp_val(32'h0, beat) || row !== IW'(beat / N) ||
                    col !== IW'(beat % N) || last !== (beat == N * N - 1)) begin
                    n_fail++;
                    $display("FAIL bp_beat k=%0d got data=%h last=%b exp data=%h last=%b",
                             beat, data, last, exp_val(32'h0, beat), beat == N * N - 1);
                end
                beat++;
            end
            pv = valid; pr = ready_in; pd = data; prow = row; pcol = col; pl = last;
            cyc++;
            @(negedge clk);
        end
        n_tests++;
        if (beat != N * N || valid !== 1'b0 || matrix_count !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_end got beats=%0d v=%b cnt=%0d exp beats=16 v=0 cnt=1", beat, valid, matrix_count);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        load_matrix(32'h0);
        ready_in = 1'b1;
        pulse();
        for (int k = 0; k < N * N; k++) begin
            n_tests++;
            if (valid !== 1'b1 || data !== exp_val(32'h0, k)) begin
                n_fail++;
                $display("FAIL ovr_beat k=%0d got v=%b data=%h exp data=%h", k, valid, data, exp_val(32'h0, k));
            end
            if (k == 5) begin
                n_tests++;
                if (overrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ovr_pre got %b exp 0", overrun);
                end
                c_in = '1;
                valid_result = 1'b1;
            end else if (k == 6) begin
                n_tests++;
                if (overrun !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovr_set got %b exp 1", overrun);
                end
                valid_result = 1'b0;
            end else if (k == 9) begin
                valid_result = 1'b1;
                clear_overrun = 1'b1;
            end else if (k == 10) begin
                n_tests++;
                if (overrun !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovr_set_wins got %b exp 1", overrun);
                end
                valid_result = 1'b0;
                clear_overrun = 1'b0;
            end
            @(negedge clk);
        end
        n_tests++;
        if (ready_out !== 1'b1 || matrix_count !== 16'd1 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_end got rdy=%b cnt=%0d ovr=%b exp rdy=1 cnt=1 ovr=1", ready_out, matrix_count, overrun);
        end
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear got %b exp 0", overrun);
        end
    endtask

    task automatic test_back_to_back();
        int   beat;
        int   cyc;
        int   gap_beat;
        logic sent;
        do_reset();
        load_matrix(32'h0);
        ready_in = 1'b1;
        pulse();
        beat = 0; cyc = 0; sent = 1'b0; gap_beat = -1;
        while (beat < 2 * N * N && cyc < 100) begin
            valid_result = 1'b0;
            if (valid) begin
                n_tests++;
                if (data !== exp_val((beat < N * N) ? 32'h0 : 32'h100, beat % (N * N)) ||
                    last !== (beat % (N * N) == N * N - 1)) begin
                    n_fail++;
                    $display("FAIL b2b_beat k=%0d got data=%h last=%b exp data=%h",
                             beat, data, last, exp_val((beat < N * N) ? 32'h0 : 32'h100, beat % (N * N)));
                end
                beat++;
            end else if (ready_out && !sent) begin
                gap_beat = beat;
                load_matrix(32'h100);
                valid_result = 1'b1;
                sent = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        valid_result = 1'b0;
        n_tests++;
        if (beat != 2 * N * N || cyc != 2 * N * N + 1 || gap_beat != N * N || matrix_count !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b_end got beats=%0d cycles=%0d gap_at=%0d cnt=%0d exp 32 33 16 2",
                     beat, cyc, gap_beat, matrix_count);
        end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        load_matrix(32'h0);
        ready_in = 1'b1;
        pulse();
        repeat (8) @(negedge clk);  // beats 0..7 accepted
        arst = 1'b1;
        #1;
        n_tests++;
        if (valid !== 1'b0 || ready_out !== 1'b1 || last !== 1'b0 || matrix_count !== 16'd0 ||
            row !== '0 || col !== '0 || data !== 32'd0) begin
            n_fail++;
            $display("FAIL midrst_async got v=%b rdy=%b l=%b cnt=%0d r=%0d c=%0d data=%h exp 0 1 0 0 0 0 0",
                     valid, ready_out, last, matrix_count, row, col, data);
        end
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_quiet i=%0d got v=%b exp 0", i, valid);
            end
        end
        load_matrix(32'h200);
        pulse();
        for (int k = 0; k < N * N; k++) begin
            n_tests++;
            if (valid !== 1'b1 || data !== exp_val(32'h200, k) || row !== IW'(k / N) || col !== IW'(k % N)) begin
                n_fail++;
                $display("FAIL midrst_beat k=%0d got v=%b data=%h r=%0d c=%0d exp data=%h",
                         k, valid, data, row, col, exp_val(32'h200, k));
            end
            @(negedge clk);
        end
        n_tests++;
        if (matrix_count !== 16'd1) begin
            n_fail++;
            $display("FAIL midrst_count got %0d exp 1", matrix_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.r_matrix_count = 16'hFFFF;
        #1;
        release dut.r_matrix_count;
        n_tests++;
        if (matrix_count !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_preload got %h exp ffff", matrix_count);
        end
        load_matrix(32'h0);
        ready_in = 1'b1;
        pulse();
        repeat (N * N) @(negedge clk);
        n_tests++;
        if (matrix_count !== 16'h0000 || ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_count got cnt=%h rdy=%b exp cnt=0000 rdy=1", matrix_count, ready_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_reset_mid_stream();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
